ppt_pulse_controller: RTL and testbench
=======================================

Name: ppt_pulse_controller

Overview:
Pulsed-plasma-thruster firing engine that sits directly downstream of the register map. It consumes clk_div, period, width, count and run_ppt, and drives the thruster trigger output. It returns count_done and done for I2C readback.
The block generates `count` trigger pulses, each `width` ticks high, repeating every `period` ticks. The tick rate is the system clock divided by 2^(clk_div+1).

Parameters:
TIME_W, 14, width of period/width/tick counter
FIRE_W, 8, width of count/count_done
PRESC_W, 32, prescaler counter width (must hold 2^(clk_div max+1)-1)

Ports:
clk  in  1  system clock (32.768 kHz oscillator domain)
rst  in  1  synchronous reset, active-high
clk_div  in  5  tick = clk / 2^(clk_div+1)
period  in  TIME_W  firing period in ticks
width  in  TIME_W  pulse high time in ticks
count  in  FIRE_W  number of firings per run
run_ppt  in  1  level enable; 1 = run/hold result, 0 = abort/clear
ppt_out  out  1  registered thruster trigger
count_done  out  FIRE_W  completed firings in current/last run
done  out  1  run completed
busy  out  1  high in FIRE or WAIT

Behaviour:
- Reset values: ppt_out=0, count_done=0, done=0, busy=0, state=IDLE, prescaler=0, tick_cnt=0.
- Config latching:
  - clk_div, period, width and count are captured on the IDLE->FIRE transition.
  - Writes to these inputs mid-run have no effect until the next run.
  - Effective period eff_p = max(period, width, 1).
- Prescaler:
  - Counts 0..2^(clk_div_l+1)-1 and wraps.
  - tick=1 for one clk on the terminal value.
  - Cleared on IDLE->FIRE and on every firing restart.
- State IDLE:
  - Entered when run_ppt=1 and done=0.
  - If count=0: go directly to DONE next cycle (done=1, count_done=0, no pulse).
  - Otherwise: clear count_done, clear tick_cnt, go to FIRE. ppt_out=1 from the next cycle if width>0.
- State FIRE (pulse high):
  - On tick, tick_cnt++.
  - When tick_cnt reaches width, ppt_out goes 0 and the state moves to WAIT.
  - width=0: FIRE is left in one cycle and ppt_out never asserts; the firing still counts.
- State WAIT:
  - On tick with tick_cnt+1 == eff_p, the firing completes and count_done++.
  - If count_done+1 == count_l: go to DONE.
  - Else: tick_cnt=0, prescaler cleared, re-enter FIRE (ppt_out=1 on the next cycle).
  - The same end-of-period check also applies in FIRE when width == eff_p, i.e. back-to-back pulses.
- State DONE:
  - done=1, ppt_out=0, count_done holds.
  - Stays in DONE while run_ppt=1.
  - run_ppt=0: go to IDLE and clear done. count_done holds its value until the next start.
- Abort: run_ppt=0 in FIRE or WAIT goes to IDLE next cycle.
  - ppt_out drops in that cycle.
  - done stays 0; count_done keeps the partial count.
- Latency:
  - Pulse period in clk cycles = eff_p * 2^(clk_div+1).
  - High time = width * 2^(clk_div+1).
  - First rising edge is 1 clk after the start decision.
- rst has priority over all events. Asserted mid-pulse, it forces ppt_out=0 on the next edge.
- count_done never wraps; the maximum is count_l (255).

Decomposition:
- Package ppt_pkg holds:
  - state enum {IDLE, FIRE, WAIT, DONE}
  - TIME_W, FIRE_W, PRESC_W constants
  - the reset default constants shared with the register map (CLK_DIV=9, PERIOD=128, WIDTH=1, COUNT=16)
- Sub-module ppt_prescaler: clk, rst, clr, clk_div -> tick. It is a natural split.
- FSM and counters stay in the top module.

Test Plan:
- clk_div=0, period=4, width=1, count=3, run_ppt=1 -> ppt_out high 2 clk, low 6 clk, three times; count_done steps 1,2,3; done=1 exactly 24 clk after start.
- Reset defaults (clk_div=9, period=128, width=1, count=16) -> ppt_out high 1024 clk every 131072 clk; done after 16 firings.
- count=0, run_ppt=1 -> done=1 after 1 clk, count_done=0, ppt_out never high.
- clk_div=0, period=2, width=5, count=2 -> eff_p=5, pulse continuously high 20 clk; count_done=2, done=1.
- run_ppt dropped during 2nd firing (count=4) -> ppt_out=0 next clk, done=0, count_done=1; re-assert -> count_done clears to 0, new run starts.
- In DONE, write period=8 while run_ppt=1 -> no new pulses. Toggle run_ppt 1->0->1 -> done clears, new run uses period=8.

Source files
------------

// File: rtl/ppt_pkg.sv
// Shared types and constants for the pulsed-plasma-thruster firing engine.
// The DEF_* values are the power-on defaults also used by the register map.
package ppt_pkg;

  localparam int TIME_W  = 14;
  localparam int FIRE_W  = 8;
  localparam int PRESC_W = 32;
  localparam int DIV_W   = 5;

  localparam logic [DIV_W-1:0]  DEF_CLK_DIV = 5'd9;
  localparam logic [TIME_W-1:0] DEF_PERIOD  = 14'd128;
  localparam logic [TIME_W-1:0] DEF_WIDTH   = 14'd1;
  localparam logic [FIRE_W-1:0] DEF_COUNT   = 8'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } ppt_state_e;

  // A pulse never outlasts its period, and a zero period still takes one tick.
  function automatic logic [TIME_W-1:0] eff_period(input logic [TIME_W-1:0] period,
                                                   input logic [TIME_W-1:0] width);
    logic [TIME_W-1:0] m;
    m = (width > period) ? width : period;
    return (m == {TIME_W{1'b0}}) ? TIME_W'(1) : m;
  endfunction

endpackage

// File: rtl/ppt_prescaler.sv
// Tick generator: one-clock tick every 2^(clk_div+1) clocks, restartable via clr.
module ppt_prescaler
  import ppt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic [PRESC_W-1:0] term_s;
  logic [DIV_W-1:0]   shamt_s;

  assign shamt_s = DIV_W'(PRESC_W - 1) - clk_div;
  assign term_s  = {PRESC_W{1'b1}} >> shamt_s;
  assign tick    = (cnt_q == term_s);

  // Next count: restart on clr, wrap after the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {PRESC_W{1'b0}};
    end else if (tick) begin
      cnt_d = {PRESC_W{1'b0}};
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {PRESC_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ppt_pulse_controller.sv
// Thruster firing engine: emits `count` pulses of `width` ticks every eff_period ticks,
// with configuration frozen at run start and level-sensitive run/abort control.
module ppt_pulse_controller
  import ppt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [TIME_W-1:0] period,
  input  logic [TIME_W-1:0] width,
  input  logic [FIRE_W-1:0] count,
  input  logic              run_ppt,
  output logic              ppt_out,
  output logic [FIRE_W-1:0] count_done,
  output logic              done,
  output logic              busy
);

  ppt_state_e        state_q, state_d;
  logic [DIV_W-1:0]  clk_div_q, clk_div_d;
  logic [TIME_W-1:0] eff_p_q, eff_p_d;
  logic [TIME_W-1:0] width_q, width_d;
  logic [FIRE_W-1:0] count_q, count_d;
  logic [TIME_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [FIRE_W-1:0] count_done_q, count_done_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ppt_out_q, ppt_out_d;

  logic              tick_s;
  logic              presc_clr_s;
  logic [TIME_W-1:0] tick_inc_s;
  logic              period_end_s;
  logic              last_fire_s;

  ppt_prescaler u_presc (
    .clk     (clk),
    .rst     (rst),
    .clr     (presc_clr_s),
    .clk_div (clk_div_q),
    .tick    (tick_s)
  );

  assign tick_inc_s   = tick_cnt_q + TIME_W'(1);
  assign period_end_s = tick_s && (tick_inc_s == eff_p_q);
  assign last_fire_s  = ((count_done_q + FIRE_W'(1)) == count_q);

  // Next-state and next-output logic for the firing sequencer.
  always_comb begin
    state_d      = state_q;
    clk_div_d    = clk_div_q;
    eff_p_d      = eff_p_q;
    width_d      = width_q;
    count_d      = count_q;
    tick_cnt_d   = tick_cnt_q;
    count_done_d = count_done_q;
    done_d       = done_q;
    ppt_out_d    = ppt_out_q;
    presc_clr_s  = 1'b0;

    case (state_q)
      IDLE: begin
        if (run_ppt) begin
          clk_div_d    = clk_div;
          eff_p_d      = eff_period(period, width);
          width_d      = width;
          count_d      = count;
          tick_cnt_d   = {TIME_W{1'b0}};
          count_done_d = {FIRE_W{1'b0}};
          presc_clr_s  = 1'b1;
          if (count == {FIRE_W{1'b0}}) begin
            state_d   = DONE;
            done_d    = 1'b1;
            ppt_out_d = 1'b0;
          end else begin
            state_d   = FIRE;
            done_d    = 1'b0;
            ppt_out_d = (width != {TIME_W{1'b0}});
          end
        end else begin
          done_d    = 1'b0;
          ppt_out_d = 1'b0;
        end
      end

      FIRE, WAIT: begin
        if (!run_ppt) begin
          state_d   = IDLE;
          ppt_out_d = 1'b0;
        end else if (period_end_s) begin
          // End of period is checked before the pulse-low edge so width == eff_p stays high.
          count_done_d = count_done_q + FIRE_W'(1);
          if (last_fire_s) begin
            state_d   = DONE;
            done_d    = 1'b1;
            ppt_out_d = 1'b0;
          end else begin
            state_d     = FIRE;
            tick_cnt_d  = {TIME_W{1'b0}};
            presc_clr_s = 1'b1;
            ppt_out_d   = (width_q != {TIME_W{1'b0}});
          end
        end else if ((state_q == FIRE) && (width_q == {TIME_W{1'b0}})) begin
          state_d   = WAIT;
          ppt_out_d = 1'b0;
        end else if (tick_s) begin
          tick_cnt_d = tick_inc_s;
          if ((state_q == FIRE) && (tick_inc_s == width_q)) begin
            state_d   = WAIT;
            ppt_out_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      DONE: begin
        ppt_out_d = 1'b0;
        if (!run_ppt) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d   = IDLE;
        done_d    = 1'b0;
        ppt_out_d = 1'b0;
      end
    endcase

    busy_d = (state_d == FIRE) || (state_d == WAIT);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_div_q    <= DEF_CLK_DIV;
      eff_p_q      <= eff_period(DEF_PERIOD, DEF_WIDTH);
      width_q      <= DEF_WIDTH;
      count_q      <= DEF_COUNT;
      tick_cnt_q   <= {TIME_W{1'b0}};
      count_done_q <= {FIRE_W{1'b0}};
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      ppt_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_div_q    <= clk_div_d;
      eff_p_q      <= eff_p_d;
      width_q      <= width_d;
      count_q      <= count_d;
      tick_cnt_q   <= tick_cnt_d;
      count_done_q <= count_done_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      ppt_out_q    <= ppt_out_d;
    end
  end

  assign ppt_out    = ppt_out_q;
  assign count_done = count_done_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ppt_pulse_controller.sv
// Self-checking bench: closed-form timing model of a run plus directed literal checks.
module tb_ppt_pulse_controller;
  import ppt_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  clk_div;
  logic [TIME_W-1:0] period;
  logic [TIME_W-1:0] width;
  logic [FIRE_W-1:0] count;
  logic              run_ppt;
  logic              ppt_out;
  logic [FIRE_W-1:0] count_done;
  logic              done;
  logic              busy;

  ppt_pulse_controller dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
    .ppt_out    (ppt_out),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is described by the clock index k since its start edge (k=1 is the
  // first FIRE clock), the period P and high time H in clocks, and the firing count.
  int     m_phase = 0;   // 0 idle, 1 running, 2 finished
  longint m_k = 0;
  longint m_p = 1;
  longint m_h = 0;
  longint m_cnt = 0;
  longint m_cd_hold = 0;

  function automatic longint eff_ticks(input longint p, input longint w);
    longint m;
    m = (w > p) ? w : p;
    return (m < 1) ? 1 : m;
  endfunction

  function automatic longint tick_clks(input int d);
    return longint'(1) << (d + 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase   <= 0;
      m_k       <= 0;
      m_cd_hold <= 0;
    end else begin
      case (m_phase)
        0: if (run_ppt) begin
          m_p       <= eff_ticks(longint'(period), longint'(width)) * tick_clks(int'(clk_div));
          m_h       <= longint'(width) * tick_clks(int'(clk_div));
          m_cnt     <= longint'(count);
          m_k       <= 1;
          m_cd_hold <= 0;
          m_phase   <= (count == 8'd0) ? 2 : 1;
        end
        1: if (!run_ppt) begin
          m_cd_hold <= (m_k - 1) / m_p;
          m_phase   <= 0;
        end else begin
          m_k <= m_k + 1;
          if (m_k + 1 > m_cnt * m_p) begin
            m_phase   <= 2;
            m_cd_hold <= m_cnt;
          end
        end
        2: if (!run_ppt) m_phase <= 0;
        default: m_phase <= 0;
      endcase
    end
  end

  function automatic longint exp_ppt();
    return (m_phase == 1 && ((m_k - 1) % m_p) < m_h) ? 1 : 0;
  endfunction

  function automatic longint exp_cd();
    return (m_phase == 1) ? (m_k - 1) / m_p : m_cd_hold;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ppt_out", longint'(ppt_out), exp_ppt());
      check("count_done", longint'(count_done), exp_cd());
      check("done", longint'(done), (m_phase == 2) ? 1 : 0);
      check("busy", longint'(busy), (m_phase == 1) ? 1 : 0);
    end
  end

  task automatic start(input int d, input int p, input int w, input int c);
    @(negedge clk);
    clk_div = DIV_W'(d);
    period  = TIME_W'(p);
    width   = TIME_W'(w);
    count   = FIRE_W'(c);
    run_ppt = 1'b1;
  endtask

  task automatic stop();
    @(negedge clk);
    run_ppt = 1'b0;
    @(negedge clk);
  endtask

  int hi, first_hi, first_done, run_len, max_run, nr;
  int rise [2];
  bit prev;

  initial begin
    rst = 1'b1; run_ppt = 1'b0;
    clk_div = DEF_CLK_DIV; period = DEF_PERIOD; width = DEF_WIDTH; count = DEF_COUNT;
    repeat (3) @(negedge clk);
    check("rst_ppt_out", longint'(ppt_out), 0);
    check("rst_count_done", longint'(count_done), 0);
    check("rst_done", longint'(done), 0);
    check("rst_busy", longint'(busy), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic: 2 clk high, 6 low, three times.
    start(0, 4, 1, 3);
    hi = 0; first_hi = -1; first_done = -1;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (ppt_out) begin hi++; if (first_hi < 0) first_hi = n; end
      if (done && first_done < 0) first_done = n;
    end
    check("t1_first_rise", first_hi, 1);
    check("t1_high_clks", hi, 6);
    check("t1_done_latency", first_done - first_hi, 24);
    check("t1_count_done", longint'(count_done), 3);
    stop();

    // Reset defaults: first pulse is 1024 clocks wide; then abort.
    start(int'(DEF_CLK_DIV), int'(DEF_PERIOD), int'(DEF_WIDTH), int'(DEF_COUNT));
    hi = 0;
    for (int n = 1; n <= 1100; n++) begin
      @(negedge clk);
      if (ppt_out) hi++;
    end
    check("def_high_clks", hi, 1024);
    stop();
    check("def_abort_cd", longint'(count_done), 0);
    check("def_abort_done", longint'(done), 0);

    // count = 0 finishes at once with no pulse.
    start(0, 4, 1, 0);
    @(negedge clk);
    check("c0_done", longint'(done), 1);
    hi = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (ppt_out) hi++;
    end
    check("c0_high_clks", hi, 0);
    check("c0_count_done", longint'(count_done), 0);
    stop();

    // width > period: back-to-back pulses merge into one 20-clock high.
    start(0, 2, 5, 2);
    run_len = 0; max_run = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      run_len = ppt_out ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
    check("cont_high_run", max_run, 20);
    check("cont_count_done", longint'(count_done), 2);
    check("cont_done", longint'(done), 1);
    stop();

    // Abort during the second firing, then restart.
    start(0, 4, 1, 4);
    repeat (9) @(negedge clk);
    check("ab_second_pulse", longint'(ppt_out), 1);
    run_ppt = 1'b0;
    @(negedge clk);
    check("ab_ppt_out", longint'(ppt_out), 0);
    check("ab_done", longint'(done), 0);
    check("ab_count_done", longint'(count_done), 1);
    run_ppt = 1'b1;
    @(negedge clk);
    check("ab_restart_cd", longint'(count_done), 0);
    check("ab_restart_ppt", longint'(ppt_out), 1);
    stop();

    // Writes while finished are ignored until the next run.
    start(0, 4, 1, 1);
    repeat (12) @(negedge clk);
    check("hold_done", longint'(done), 1);
    period = 14'd8; count = 8'd2;
    hi = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ppt_out) hi++;
    end
    check("hold_no_pulse", hi, 0);
    run_ppt = 1'b0;
    @(negedge clk);
    check("hold_done_clr", longint'(done), 0);
    run_ppt = 1'b1;
    nr = 0; prev = 1'b0; rise[0] = -1; rise[1] = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ppt_out && !prev) begin
        if (nr < 2) rise[nr] = n;
        nr++;
      end
      prev = ppt_out;
    end
    check("p8_rise1", rise[0], 1);
    check("p8_rise2", rise[1], 17);
    check("p8_count_done", longint'(count_done), 2);
    stop();

    // Randomized runs: mid-run writes, aborts, run_ppt toggles and resets.
    for (int r = 0; r < 40; r++) begin
      start(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
      for (int i = 0; i < int'($urandom_range(1, 250)); i++) begin
        @(negedge clk);
        rst = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 19) == 0) begin
          clk_div = DIV_W'($urandom_range(0, 2));
          period  = TIME_W'($urandom_range(0, 6));
          width   = TIME_W'($urandom_range(0, 6));
          count   = FIRE_W'($urandom_range(0, 4));
        end
        if ($urandom_range(0, 49) == 0) run_ppt = ~run_ppt;
      end
      @(negedge clk);
      rst = 1'b0;
      run_ppt = 1'b0;
      repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
